// File: rtl/avl_bus_arbiter.sv
// avl_bus_arbiter: shares one avl slave port between MASTER_NUM masters.
// Round-robin grant with burst locking. The request path is purely
// combinational. Read responses are steered back to their issuers in issue
// order using a small FIFO of master ids.
module avl_bus_arbiter #(
  parameter int MASTER_NUM      = 4,
  parameter int BURST_W         = 8,
  parameter int RESP_FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rest,
  // master side
  input  logic [MASTER_NUM*32-1:0]      m_address,
  input  logic [MASTER_NUM*4-1:0]       m_byte_en,
  input  logic [MASTER_NUM-1:0]         m_read,
  input  logic [MASTER_NUM-1:0]         m_write,
  input  logic [MASTER_NUM*32-1:0]      m_write_data,
  input  logic [MASTER_NUM-1:0]         m_begin_burst_transfer,
  input  logic [MASTER_NUM*BURST_W-1:0] m_burst_count,
  output logic [MASTER_NUM-1:0]         m_request_ready,
  output logic [MASTER_NUM*32-1:0]      m_read_data,
  output logic [MASTER_NUM-1:0]         m_read_data_valid,
  input  logic [MASTER_NUM-1:0]         m_resp_ready,
  // slave side
  output logic [31:0]                   s_address,
  output logic [3:0]                    s_byte_en,
  output logic                          s_read,
  output logic                          s_write,
  output logic [31:0]                   s_write_data,
  output logic                          s_begin_burst_transfer,
  output logic [BURST_W-1:0]            s_burst_count,
  input  logic                          s_request_ready,
  input  logic [31:0]                   s_read_data,
  input  logic                          s_read_data_valid,
  output logic                          s_resp_ready
);

  localparam int PW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam int AW = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(RESP_FIFO_DEPTH) + 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // arbitration state
  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   lock_id_q, lock_id_d;

  // read id fifo
  logic [PW-1:0]   id_mem_q [RESP_FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            fifo_full, fifo_empty;
  logic [PW-1:0]   head_id;
  logic            push, pop;

  // per-master views of the packed command vectors
  logic [31:0]         addr_arr  [MASTER_NUM];
  logic [3:0]          be_arr    [MASTER_NUM];
  logic [31:0]         wdata_arr [MASTER_NUM];
  logic [BURST_W-1:0]  bc_arr    [MASTER_NUM];
  logic [MASTER_NUM-1:0] req_vec;

  // combinational arbitration results
  logic [PW-1:0]   rr_pick;
  logic            rr_found;
  logic [PW-1:0]   grant_id;
  logic            grant_valid;
  logic            g_read, g_write, read_blocked;
  logic            accept;

  genvar gi;
  generate
    for (gi = 0; gi < MASTER_NUM; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_address[gi*32 +: 32];
      assign be_arr[gi]    = m_byte_en[gi*4 +: 4];
      assign wdata_arr[gi] = m_write_data[gi*32 +: 32];
      assign bc_arr[gi]    = m_burst_count[gi*BURST_W +: BURST_W];
      assign req_vec[gi]   = m_read[gi] | m_write[gi];
    end
  endgenerate

  // Every master sees the slave's data; the valid bit selects the receiver.
  assign m_read_data = {MASTER_NUM{s_read_data}};

  // Increment an id modulo MASTER_NUM (MASTER_NUM need not be a power of 2).
  function automatic logic [PW-1:0] next_id(input logic [PW-1:0] id);
    next_id = (id == PW'(MASTER_NUM - 1)) ? '0 : id + 1'b1;
  endfunction

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    rr_pick  = '0;
    rr_found = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= MASTER_NUM) idx = idx - MASTER_NUM;
      cand = PW'(idx);
      if (!rr_found && req_vec[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  // State register: burst lock and round-robin pointer.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Next-state: lock on a multi-beat burst start, release on its last beat.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (s_begin_burst_transfer && (s_burst_count != '0)) begin
            state_d   = ST_LOCKED;
            lock_id_d = grant_id;
          end else begin
            rr_ptr_d = next_id(grant_id);
          end
        end
      end
      ST_LOCKED: begin
        if (accept && (s_burst_count == '0)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_id(lock_id_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: grant selection, command mux and per-master request_ready.
  // Reset gates the grant so every command output drops at once.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = rr_pick;
    if (!rest) begin
      if (state_q == ST_LOCKED) begin
        grant_valid = 1'b1;
        grant_id    = lock_id_q;
      end else begin
        grant_valid = rr_found;
        grant_id    = rr_pick;
      end
    end

    g_read       = grant_valid & m_read[grant_id];
    g_write      = grant_valid & m_write[grant_id];
    read_blocked = g_read & fifo_full;

    s_address              = addr_arr[grant_id];
    s_byte_en              = be_arr[grant_id];
    s_write_data           = wdata_arr[grant_id];
    s_burst_count          = bc_arr[grant_id];
    s_begin_burst_transfer = grant_valid & m_begin_burst_transfer[grant_id];
    s_read                 = g_read & ~fifo_full;
    s_write                = g_write & ~read_blocked;

    m_request_ready = '0;
    if (grant_valid && s_request_ready && !read_blocked) begin
      m_request_ready[grant_id] = 1'b1;
    end

    accept = (g_read | g_write) & s_request_ready & ~read_blocked;
    push   = accept & g_read;
  end

  // Response routing: the FIFO head owns whatever the slave returns.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(RESP_FIFO_DEPTH));
  assign head_id    = id_mem_q[rd_ptr_q];
  assign s_resp_ready = ~fifo_empty & m_resp_ready[head_id];
  assign pop          = s_read_data_valid & s_resp_ready;

  // One-hot valid to the head master; a response with nothing outstanding is dropped.
  always_comb begin
    m_read_data_valid = '0;
    if (s_read_data_valid && !fifo_empty) begin
      m_read_data_valid[head_id] = 1'b1;
    end
  end

  // FIFO pointers and occupancy; push is already suppressed when full.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage: the id of the master that issued each accepted read beat.
  always_ff @(posedge clk) begin
    if (push) id_mem_q[wr_ptr_q] <= grant_id;
  end

  // Flag a slave response that arrives with no read outstanding.
  assert property (@(posedge clk) disable iff (rest) !(s_read_data_valid && fifo_empty))
    else $error("avl_bus_arbiter: read response with no outstanding read, dropped");

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// Directed testbench for avl_bus_arbiter (MASTER_NUM=4, BURST_W=8, depth 8).
module tb_avl_bus_arbiter;

  localparam int N  = 4;
  localparam int BW = 8;

  logic            clk;
  logic            rest;
  logic [N*32-1:0] m_address;
  logic [N*4-1:0]  m_byte_en;
  logic [N-1:0]    m_read;
  logic [N-1:0]    m_write;
  logic [N*32-1:0] m_write_data;
  logic [N-1:0]    m_begin_burst_transfer;
  logic [N*BW-1:0] m_burst_count;
  logic [N-1:0]    m_request_ready;
  logic [N*32-1:0] m_read_data;
  logic [N-1:0]    m_read_data_valid;
  logic [N-1:0]    m_resp_ready;
  logic [31:0]     s_address;
  logic [3:0]      s_byte_en;
  logic            s_read;
  logic            s_write;
  logic [31:0]     s_write_data;
  logic            s_begin_burst_transfer;
  logic [BW-1:0]   s_burst_count;
  logic            s_request_ready;
  logic [31:0]     s_read_data;
  logic            s_read_data_valid;
  logic            s_resp_ready;

  int tests_run;
  int tests_failed;

  avl_bus_arbiter #(.MASTER_NUM(N), .BURST_W(BW), .RESP_FIFO_DEPTH(8)) dut (
    .clk                    (clk),
    .rest                   (rest),
    .m_address              (m_address),
    .m_byte_en              (m_byte_en),
    .m_read                 (m_read),
    .m_write                (m_write),
    .m_write_data           (m_write_data),
    .m_begin_burst_transfer (m_begin_burst_transfer),
    .m_burst_count          (m_burst_count),
    .m_request_ready        (m_request_ready),
    .m_read_data            (m_read_data),
    .m_read_data_valid      (m_read_data_valid),
    .m_resp_ready           (m_resp_ready),
    .s_address              (s_address),
    .s_byte_en              (s_byte_en),
    .s_read                 (s_read),
    .s_write                (s_write),
    .s_write_data           (s_write_data),
    .s_begin_burst_transfer (s_begin_burst_transfer),
    .s_burst_count          (s_burst_count),
    .s_request_ready        (s_request_ready),
    .s_read_data            (s_read_data),
    .s_read_data_valid      (s_read_data_valid),
    .s_resp_ready           (s_resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int i, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic bb, input logic [BW-1:0] bc);
    m_read[i]                 = rd;
    m_write[i]                = wr;
    m_address[i*32 +: 32]     = addr;
    m_write_data[i*32 +: 32]  = addr ^ 32'h5555_0000;
    m_byte_en[i*4 +: 4]       = 4'hF;
    m_begin_burst_transfer[i] = bb;
    m_burst_count[i*BW +: BW] = bc;
  endtask

  task automatic idle_all();
    m_read                 = '0;
    m_write                = '0;
    m_begin_burst_transfer = '0;
    m_burst_count          = '0;
  endtask

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    rest              = 1'b1;
    m_address         = '0;
    m_byte_en         = '0;
    m_write_data      = '0;
    idle_all();
    m_resp_ready      = '1;
    s_request_ready   = 1'b1;
    s_read_data       = '0;
    s_read_data_valid = 1'b0;

    // Reset: requests present but every output held low.
    drive(0, 1'b1, 1'b0, 32'h0000_1000, 1'b0, 8'd0);
    drive(2, 1'b1, 1'b0, 32'h0000_3000, 1'b0, 8'd0);
    repeat (2) tick();
    settle();
    check("rst_req_ready", 32'(m_request_ready), 32'h0);
    check("rst_s_read", 32'(s_read), 32'h0);
    check("rst_s_write", 32'(s_write), 32'h0);
    check("rst_s_resp_ready", 32'(s_resp_ready), 32'h0);
    check("rst_rd_valid", 32'(m_read_data_valid), 32'h0);

    // Alternating single reads from M0 and M2, rr_ptr starts at 0.
    rest = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("rr_ready_%0d", k), 32'(m_request_ready), (k % 2 == 0) ? 32'h1 : 32'h4);
      check($sformatf("rr_addr_%0d", k), s_address, (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_3000);
      tick();
    end
    idle_all();
    // Drain the four responses in issue order 0,2,0,2.
    for (int k = 0; k < 4; k++) begin
      s_read_data_valid = 1'b1;
      s_read_data       = 32'(k);
      settle();
      check($sformatf("rr_resp_%0d", k), 32'(m_read_data_valid), (k % 2 == 0) ? 32'h1 : 32'h4);
      tick();
    end
    s_read_data_valid = 1'b0;

    // Burst write from M1 (count 3) locks out M0 for all four beats.
    drive(1, 1'b0, 1'b1, 32'h0000_2000, 1'b1, 8'd3);
    settle();
    check("burst_ready_b0", 32'(m_request_ready), 32'h2);
    check("burst_cnt_b0", 32'(s_burst_count), 32'd3);
    tick();
    drive(0, 1'b0, 1'b1, 32'h0000_1100, 1'b0, 8'd0);
    for (int b = 1; b < 4; b++) begin
      drive(1, 1'b0, 1'b1, 32'h0000_2000 + 32'(4 * b), 1'b0, 8'(3 - b));
      settle();
      check($sformatf("burst_ready_b%0d", b), 32'(m_request_ready), 32'h2);
      check($sformatf("burst_cnt_b%0d", b), 32'(s_burst_count), 32'(3 - b));
      tick();
    end
    m_write[1] = 1'b0;
    settle();
    check("burst_after_m0", 32'(m_request_ready), 32'h1);
    tick();
    idle_all();

    // In-order response routing: M0 reads 0x100, then M3 reads 0x200.
    drive(0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 8'd0);
    settle();
    check("ord_m0_addr", s_address, 32'h0000_0100);
    check("ord_m0_sread", 32'(s_read), 32'h1);
    tick();
    m_read[0] = 1'b0;
    drive(3, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 8'd0);
    settle();
    check("ord_m3_addr", s_address, 32'h0000_0200);
    check("ord_m3_ready", 32'(m_request_ready), 32'h8);
    tick();
    idle_all();
    s_read_data_valid = 1'b1;
    s_read_data       = 32'hAAAA_0000;
    settle();
    check("ord_resp0_valid", 32'(m_read_data_valid), 32'h1);
    check("ord_resp0_data", m_read_data[0 +: 32], 32'hAAAA_0000);
    tick();
    s_read_data = 32'hBBBB_0000;
    settle();
    check("ord_resp1_valid", 32'(m_read_data_valid), 32'h8);
    check("ord_resp1_data", m_read_data[96 +: 32], 32'hBBBB_0000);
    tick();
    s_read_data_valid = 1'b0;
    settle();
    check("ord_resp_none", 32'(m_read_data_valid), 32'h0);

    // FIFO full: 8 reads accepted, 9th stalls, writes still flow.
    drive(0, 1'b1, 1'b0, 32'h0000_0300, 1'b0, 8'd0);
    for (int k = 0; k < 8; k++) begin
      settle();
      check($sformatf("full_fill_%0d", k), 32'(m_request_ready), 32'h1);
      tick();
    end
    drive(1, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 8'd0);
    settle();
    check("full_wr_ready", 32'(m_request_ready), 32'h2);
    check("full_wr_swrite", 32'(s_write), 32'h1);
    tick();
    m_write[1] = 1'b0;
    settle();
    check("full_rd_stall", 32'(m_request_ready), 32'h0);
    check("full_rd_sread", 32'(s_read), 32'h0);
    s_read_data_valid = 1'b1;
    s_read_data       = 32'h0000_00C0;
    settle();
    check("full_pop_no_push", 32'(m_request_ready), 32'h0);
    check("full_pop_rready", 32'(s_resp_ready), 32'h1);
    tick();
    s_read_data_valid = 1'b0;
    settle();
    check("full_unblock", 32'(m_request_ready), 32'h1);
    tick();
    m_read[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s_read_data_valid = 1'b1;
      settle();
      check($sformatf("full_drain_%0d", k), 32'(m_read_data_valid), 32'h1);
      tick();
    end
    s_read_data_valid = 1'b0;
    settle();
    check("full_empty_rready", 32'(s_resp_ready), 32'h0);

    // Response back-pressure from the head master (M2).
    drive(2, 1'b1, 1'b0, 32'h0000_0500, 1'b0, 8'd0);
    settle();
    check("bp_issue", 32'(m_request_ready), 32'h4);
    tick();
    m_read[2]         = 1'b0;
    m_resp_ready[2]   = 1'b0;
    s_read_data_valid = 1'b1;
    s_read_data       = 32'h0000_1234;
    settle();
    check("bp_rready_low", 32'(s_resp_ready), 32'h0);
    check("bp_valid", 32'(m_read_data_valid), 32'h4);
    tick();
    settle();
    check("bp_valid_held", 32'(m_read_data_valid), 32'h4);
    check("bp_data_held", m_read_data[64 +: 32], 32'h0000_1234);
    m_resp_ready[2] = 1'b1;
    settle();
    check("bp_rready_high", 32'(s_resp_ready), 32'h1);
    tick();
    s_read_data_valid = 1'b0;
    settle();
    check("bp_popped_rready", 32'(s_resp_ready), 32'h0);
    check("bp_popped_valid", 32'(m_read_data_valid), 32'h0);

    // Reset in the middle of an M2 burst with three reads outstanding.
    drive(0, 1'b1, 1'b0, 32'h0000_0600, 1'b0, 8'd0);
    repeat (3) tick();
    m_read[0] = 1'b0;
    drive(2, 1'b0, 1'b1, 32'h0000_0700, 1'b1, 8'd2);
    settle();
    check("rstb_first_beat", 32'(m_request_ready), 32'h4);
    tick();
    drive(2, 1'b0, 1'b1, 32'h0000_0704, 1'b0, 8'd1);
    drive(0, 1'b1, 1'b0, 32'h0000_0600, 1'b0, 8'd0);
    settle();
    check("rstb_locked", 32'(m_request_ready), 32'h4);
    rest              = 1'b1;
    s_read_data_valid = 1'b1;
    settle();
    check("rstb_req_ready", 32'(m_request_ready), 32'h0);
    check("rstb_s_rw", 32'({s_read, s_write}), 32'h0);
    check("rstb_s_resp_ready", 32'(s_resp_ready), 32'h0);
    check("rstb_rd_valid", 32'(m_read_data_valid), 32'h0);
    tick();
    rest              = 1'b0;
    s_read_data_valid = 1'b0;
    settle();
    check("rstb_m0_wins", 32'(m_request_ready), 32'h1);
    check("rstb_m0_addr", s_address, 32'h0000_0600);
    check("rstb_fifo_clear", 32'(s_resp_ready), 32'h0);
    tick();
    idle_all();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/avl_bus_arbiter.md
Name: avl_bus_arbiter

Overview:
- N-master to 1-slave arbiter for the avl bus: shares one slave port between MASTER_NUM masters.
- Round-robin grant; grant is locked for the duration of a burst.
- Read responses are routed back to the issuing master in issue order through an ID FIFO.
- Sits between bus masters (CPU ifetch/lsu, DMA, bench master models) and a shared slave or crossbar slave port.

Parameters:
- MASTER_NUM, 4, number of masters (2..16).
- BURST_W, 8, width of burst_count.
- RESP_FIFO_DEPTH, 8, max outstanding reads (power of 2).

Ports:
- clk  in  1  clock.
- rest  in  1  asynchronous reset, active-high.
- m_address  in  MASTER_NUM*32  per-master address; master i at bits [i*32+:32], same slicing for all m_ vectors.
- m_byte_en  in  MASTER_NUM*4  byte enables.
- m_read  in  MASTER_NUM  read request.
- m_write  in  MASTER_NUM  write request.
- m_write_data  in  MASTER_NUM*32  write data.
- m_begin_burst_transfer  in  MASTER_NUM  first beat of a burst.
- m_burst_count  in  MASTER_NUM*BURST_W  beats remaining after the current beat.
- m_request_ready  out  MASTER_NUM  beat accepted when (read|write)&request_ready.
- m_read_data  out  MASTER_NUM*32  routed read data (all masters see s_read_data).
- m_read_data_valid  out  MASTER_NUM  response valid, one-hot to the FIFO-head master.
- m_resp_ready  in  MASTER_NUM  master can take a response.
- s_address, s_byte_en, s_read, s_write, s_write_data, s_begin_burst_transfer, s_burst_count  out  32/4/1/1/32/1/BURST_W  muxed command to the slave.
- s_request_ready  in  1  slave accepts the command.
- s_read_data  in  32  slave read data.
- s_read_data_valid  in  1  slave response valid.
- s_resp_ready  out  1  equals m_resp_ready of the FIFO-head master; 0 when the FIFO is empty.

Behaviour:
- Request path is combinational (zero latency). The s_ command fields equal the granted master's fields.
- s_read and s_write are 0 when no master is granted, and are also 0 for a read while the FIFO is full.
- m_request_ready[i] = grant[i] & s_request_ready & !(m_read[i] & fifo_full).
- A master is requesting when m_read|m_write.
- States:
  - IDLE: grant goes to the first requesting master at or after rr_ptr (wrap modulo MASTER_NUM).
  - LOCKED: grant is forced to lock_id. Other masters see request_ready=0 even if requesting.
- IDLE transitions on an accepted beat:
  - begin_burst_transfer=1 and burst_count!=0: go to LOCKED, lock_id <= granted master.
  - Otherwise (single transfer, or a burst with burst_count=0): stay in IDLE, rr_ptr <= granted+1.
- LOCKED: an accepted beat with burst_count==0 returns to IDLE with rr_ptr <= lock_id+1. A non-accepted beat holds the state. If the owner drops its request, the state holds; there is no timeout.
- Read ID FIFO:
  - Push the granted id on every accepted read beat (each burst beat counts).
  - Pop on s_read_data_valid & s_resp_ready.
  - Push is blocked when full, even if a pop occurs in the same cycle. Simultaneous push and pop when not full leaves the count unchanged.
- Response routing:
  - m_read_data_valid[head] = s_read_data_valid & !fifo_empty.
  - s_read_data_valid with an empty FIFO is a protocol error: it is dropped, s_resp_ready=0, and a sim-only $error is raised.
- Writes produce no FIFO entry.
- Reset (asynchronous, immediate):
  - State=IDLE, rr_ptr=0, FIFO empty, lock cleared.
  - Outputs: all m_request_ready=0, m_read_data_valid=0, s_read=s_write=0, s_resp_ready=0.
  - A reset mid-burst or with reads outstanding discards all tracking.
- Widths: FIFO count is clog2(RESP_FIFO_DEPTH)+1 bits. rr_ptr and lock_id are max(clog2(MASTER_NUM),1) bits.

Test Plan:
- M0 and M2 both issue single reads continuously, slave always ready, rr_ptr=0 -> grants alternate 0,2,0,2; each master gets 1 accept per 2 cycles.
- M1 issues a burst write (begin=1, burst_count=3) while M0 requests -> 4 consecutive M1 beats (counts 3,2,1,0); M0 request_ready=0 throughout; M0 is granted on the cycle after the count-0 beat.
- M0 reads 0x100 and M3 reads 0x200; slave answers in order with 0xAAAA0000 then 0xBBBB0000 -> M0 gets valid with 0xAAAA0000, then M3 gets valid with 0xBBBB0000; no other valid bits are set.
- RESP_FIFO_DEPTH=8 with the slave withholding responses; M0 issues 9 reads -> 8 are accepted and the 9th is stalled (request_ready=0) while writes from M1 are still accepted; the first response unblocks the 9th read.
- Head master's resp_ready=0 while the slave holds valid -> s_resp_ready=0, no pop, data held; pop happens in the cycle resp_ready rises.
- Assert rest mid-burst (M2, count=2) with 3 reads outstanding -> all outputs are 0 immediately; after release, M0 wins first and a stray s_read_data_valid is dropped with an error.
